// File: rtl/comp_divider_host.sv
// Initiator-side sequencer for a CompDivider Run/Ready divider: takes divide requests, drives the
// clear/settle/run/wait sequence and returns quotient/remainder on a buffered response port.
module comp_divider_host #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_err,
    output logic             Div_Reset,
    output logic             Div_Run,
    output logic [WIDTH-1:0] Div_Dividend,
    output logic [WIDTH-1:0] Div_Divisor,
    input  logic [WIDTH-1:0] Div_Quotient,
    input  logic [WIDTH-1:0] Div_Remainder,
    input  logic             Div_Ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SETTLE,
        RUN,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0]   rsp_remainder_q, rsp_remainder_d;
    logic               rsp_err_q, rsp_err_d;
    logic               div_reset_q, div_reset_d;
    logic               div_run_q, div_run_d;
    logic [WIDTH-1:0]   div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0]   div_divisor_q, div_divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_dly_q, ready_dly_d;

    logic               ready_rise;
    logic               cnt_expired;

    // Only a fresh 0->1 transition of Ready counts; a level left over from the last op does not.
    assign ready_rise  = Div_Ready & ~ready_dly_q;
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every variable gets a default here so no path through the case infers a latch.
        state_d         = state_q;
        req_ready_d     = req_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_err_d       = rsp_err_q;
        div_reset_d     = 1'b0;
        div_run_d       = div_run_q;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        cnt_d           = cnt_q;
        ready_dly_d     = Div_Ready;

        unique case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d    = 1'b0;
                    div_dividend_d = req_dividend;
                    div_divisor_d  = req_divisor;
                    if (req_divisor == '0) begin
                        // Divide-by-zero is answered locally; the divider is never started.
                        state_d         = RESP;
                        rsp_valid_d     = 1'b1;
                        rsp_quotient_d  = '1;
                        rsp_remainder_d = req_dividend;
                        rsp_err_d       = 1'b1;
                    end else begin
                        state_d     = CLR;
                        div_reset_d = 1'b1;
                    end
                end
            end
            CLR: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d   = RUN;
                div_run_d = 1'b1;
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (ready_rise) begin
                    state_d         = RESP;
                    div_run_d       = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_quotient_d  = Div_Quotient;
                    rsp_remainder_d = Div_Remainder;
                    rsp_err_d       = 1'b0;
                end else if (cnt_expired) begin
                    state_d         = RESP;
                    div_run_d       = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_quotient_d  = '0;
                    rsp_remainder_d = '0;
                    rsp_err_d       = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready && rsp_valid_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q         <= IDLE;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_err_q       <= 1'b0;
            div_reset_q     <= 1'b0;
            div_run_q       <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            cnt_q           <= '0;
            ready_dly_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_ready_q     <= req_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_err_q       <= rsp_err_d;
            div_reset_q     <= div_reset_d;
            div_run_q       <= div_run_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            cnt_q           <= cnt_d;
            ready_dly_q     <= ready_dly_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_quotient  = rsp_quotient_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_err       = rsp_err_q;
    assign Div_Reset     = div_reset_q;
    assign Div_Run       = div_run_q;
    assign Div_Dividend  = div_dividend_q;
    assign Div_Divisor   = div_divisor_q;

endmodule

// File: tb/tb_comp_divider_host.sv
// Self-checking bench for comp_divider_host: a configurable divider stub plus a reference model
// that derives expected results and cycle counts from plain arithmetic.
module tb_comp_divider_host;

    localparam int W   = 32;
    localparam int TMO = 64;

    logic          clk;
    logic          Reset;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_dividend;
    logic [W-1:0]  req_divisor;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_quotient;
    logic [W-1:0]  rsp_remainder;
    logic          rsp_err;
    logic          Div_Reset;
    logic          Div_Run;
    logic [W-1:0]  Div_Dividend;
    logic [W-1:0]  Div_Divisor;
    logic [W-1:0]  Div_Quotient;
    logic [W-1:0]  Div_Remainder;
    logic          Div_Ready;

    int n_checks;
    int n_errors;

    // Stub behaviour: 0 = normal, 1 = Ready stuck low, 2 = Ready survives Div_Reset (stale level).
    int stub_mode;
    int stub_lat;
    int stub_cnt;

    comp_divider_host #(
        .WIDTH          (W),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_quotient  (rsp_quotient),
        .rsp_remainder (rsp_remainder),
        .rsp_err       (rsp_err),
        .Div_Reset     (Div_Reset),
        .Div_Run       (Div_Run),
        .Div_Dividend  (Div_Dividend),
        .Div_Divisor   (Div_Divisor),
        .Div_Quotient  (Div_Quotient),
        .Div_Remainder (Div_Remainder),
        .Div_Ready     (Div_Ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub raises Ready after stub_lat cycles of Run, presenting dividend/divisor results.
    always @(posedge clk) begin
        if (!Reset) begin
            stub_cnt      <= 0;
            Div_Ready     <= 1'b0;
            Div_Quotient  <= '0;
            Div_Remainder <= '0;
        end else if (Div_Reset) begin
            stub_cnt <= 0;
            if (stub_mode != 2) Div_Ready <= 1'b0;
        end else if (Div_Run) begin
            stub_cnt <= stub_cnt + 1;
            if (stub_cnt == 1) Div_Ready <= 1'b0;
            if (stub_mode != 1 && stub_cnt + 1 == stub_lat) begin
                Div_Ready     <= 1'b1;
                Div_Quotient  <= Div_Dividend / Div_Divisor;
                Div_Remainder <= Div_Dividend % Div_Divisor;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_req_ready();
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
    endtask

    // One full transaction: accept, sequence, optional back-pressure, handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input int lat, input int hold);
        logic [W-1:0] eq, er;
        logic         ee;
        bit           tmo;
        bit           stable;
        int           exp_runs, exp_lat;
        int           cyc, runs, resets;

        stub_mode = mode;
        stub_lat  = lat;
        tmo       = (b != 0) && (mode == 1 || lat + 1 > TMO);
        if (b == 0) begin
            eq = '1; er = a; ee = 1'b1;
        end else if (tmo) begin
            eq = '0; er = '0; ee = 1'b1;
        end else begin
            eq = a / b; er = a % b; ee = 1'b0;
        end
        exp_runs = (b == 0) ? 0 : (tmo ? TMO : lat + 1);
        exp_lat  = (b == 0) ? 0 : exp_runs + 2;

        wait_req_ready();
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        @(negedge clk);
        req_valid    = 1'b0;
        req_dividend = $urandom;
        req_divisor  = $urandom;

        runs = 0; resets = 0; cyc = 0; stable = 1'b1;
        while (!rsp_valid && cyc < 200) begin
            runs   += int'(Div_Run);
            resets += int'(Div_Reset);
            if (req_ready || Div_Dividend !== a || Div_Divisor !== b) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
        check("rsp_latency", 32'(cyc), 32'(exp_lat));
        check("div_reset_cycles", 32'(resets), (b == 0) ? 32'd0 : 32'd1);
        check("div_run_cycles", 32'(runs), 32'(exp_runs));

        // A new request held during RESP must not be taken.
        req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (!rsp_valid || rsp_quotient !== eq || rsp_remainder !== er || rsp_err !== ee ||
                req_ready || Div_Run || Div_Dividend !== a) stable = 1'b0;
            @(negedge clk);
        end
        check("rsp_quotient", rsp_quotient, eq);
        check("rsp_remainder", rsp_remainder, er);
        check("rsp_err", 32'(rsp_err), 32'(ee));
        check("resp_run_low", 32'(Div_Run), 32'd0);
        check("held_stable", 32'(stable), 32'd1);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("idle_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [W-1:0] a, b;
        int sel;

        n_checks     = 0;
        n_errors     = 0;
        stub_mode    = 0;
        stub_lat     = 4;
        Reset        = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;

        #23;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_quotient", rsp_quotient, 32'd0);
        check("rst_div_run", 32'(Div_Run), 32'd0);
        check("rst_div_reset", 32'(Div_Reset), 32'd0);
        check("rst_div_dividend", Div_Dividend, 32'd0);
        @(negedge clk);
        Reset = 1'b1;

        run_op(32'd100, 32'd7, 0, 5, 0);
        run_op(32'hFFFF_FFFF, 32'd0, 0, 5, 0);
        run_op(32'd1000, 32'd33, 0, 6, 10);
        run_op(32'd12345, 32'd11, 1, 5, 1);
        run_op(32'd9, 32'd3, 0, 4, 0);
        run_op(32'd50, 32'd5, 2, 5, 0);
        run_op(32'd51, 32'd5, 2, 5, 0);
        // Ready rise sampled on the last allowed RUN cycle, then one cycle too late.
        run_op(32'd800, 32'd9, 0, TMO - 1, 0);
        run_op(32'd800, 32'd9, 0, TMO, 0);

        // Reset mid-RUN.
        stub_mode = 0;
        stub_lat  = 40;
        wait_req_ready();
        req_valid    = 1'b1;
        req_dividend = 32'd77;
        req_divisor  = 32'd4;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!Div_Run && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_run_reached", 32'(Div_Run), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_div_run", 32'(Div_Run), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd0);
        check("abort_div_reset", 32'(Div_Reset), 32'd0);
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        run_op(32'd77, 32'd4, 0, 5, 1);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            if (sel == 0)      b = '0;
            else if (sel < 4)  b = W'($urandom_range(1, 15));
            else               b = $urandom;
            run_op(a, b, ($urandom_range(0, 1) == 1) ? 2 : 0,
                   $urandom_range(3, 10), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
